// File: rtl/proc_pkg.sv
// Shared processor package: datapath widths, reset PC and fetch FSM states.
// Imported by the fetch stage and reused by decode and later stages.
package proc_pkg;

    localparam int ADDRESS_SIZE = 32;
    localparam int INSTR_BYTES  = 4;

    localparam logic [ADDRESS_SIZE-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding buffer used by the fetch stage
// when a response returns while decode is stalled on the previous word.
module fetch_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] pc_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] pc_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] pc_q;

    // Capture on load; drain or clear empties the entry, load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            if (clear_i || drain_i) begin
                valid_q <= 1'b0;
            end
            if (load_i) begin
                valid_q <= 1'b1;
                data_q  <= data_i;
                pc_q    <= pc_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single outstanding imem request, skid, redirect.
// Optional macro FETCH_STALL_CNT_EN adds the fetch_stall_cycles counter port.
module fetch_stage
    import proc_pkg::*;
#(
    parameter int                        ADDRESS_SIZE = proc_pkg::ADDRESS_SIZE,
    parameter logic [ADDRESS_SIZE-1:0]   RESET_PC     = proc_pkg::RESET_PC,
    parameter int                        PC_STEP      = proc_pkg::INSTR_BYTES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req_valid,
    output logic [ADDRESS_SIZE-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [ADDRESS_SIZE-1:0] imem_resp_data,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    input  logic                    id_stall,
    output logic                    if_valid,
    output logic [ADDRESS_SIZE-1:0] if_instruction,
    output logic [ADDRESS_SIZE-1:0] if_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]             fetch_stall_cycles
`endif
);

    fetch_state_e state_q, state_d;

    logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
    logic [ADDRESS_SIZE-1:0] pend_q, pend_d;
    logic                    kill_q, kill_d;

    logic                    req_valid_q, req_valid_d;
    logic [ADDRESS_SIZE-1:0] req_addr_q, req_addr_d;

    logic                    if_valid_q, if_valid_d;
    logic [ADDRESS_SIZE-1:0] if_instr_q, if_instr_d;
    logic [ADDRESS_SIZE-1:0] if_pc_q, if_pc_d;

    logic                    skid_load;
    logic                    skid_drain;
    logic                    skid_clear;
    logic                    skid_valid;
    logic [ADDRESS_SIZE-1:0] skid_data;
    logic [ADDRESS_SIZE-1:0] skid_pc;

    logic [ADDRESS_SIZE-1:0] redir_tgt;
    logic                    slot_free;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redir_tgt = redirect_pc & ~(ADDRESS_SIZE'(3));
    assign slot_free = !if_valid_q || !id_stall;

    fetch_skid_buf #(
        .WIDTH (ADDRESS_SIZE)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .data_i  (imem_resp_data),
        .pc_i    (pend_q),
        .valid_o (skid_valid),
        .data_o  (skid_data),
        .pc_o    (skid_pc)
    );

    // Next-state, PC, kill and output-slot logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (if_valid_q && !id_stall) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d       = redir_tgt;
                    if_valid_d = 1'b0;
                    skid_clear = 1'b1;
                    if (imem_req_ready) begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (imem_req_ready) begin
                    pend_d  = pc_q;
                    pc_d    = pc_q + ADDRESS_SIZE'(PC_STEP);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d       = redir_tgt;
                    if_valid_d = 1'b0;
                    skid_clear = 1'b1;
                    if (imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_resp_data;
                        if_pc_d    = pend_q;
                        state_d    = FETCH;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redir_tgt;
                    if_valid_d = 1'b0;
                    skid_clear = 1'b1;
                    state_d    = FETCH;
                end else if (!id_stall) begin
                    if_valid_d = skid_valid;
                    if_instr_d = skid_data;
                    if_pc_d    = skid_pc;
                    skid_drain = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_valid_d = (state_d == FETCH);
        req_addr_d  = pc_d;
    end

    // State, PC and registered output bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_instruction = if_instr_q;
    assign if_pc          = if_pc_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles lost to decode back-pressure.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((if_valid_q && id_stall) || state_q == HOLD) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cycles = stall_cnt_q;
`else
    // Stall counter absent in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (RESET_PC = 0x100).
// Memory model: always ready, 1- or 2-cycle response latency.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic        lat2 = 1'b0;
    logic        inj = 1'b0;
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;
    logic [31:0] a1 = 32'h0;
    logic [31:0] a2 = 32'h0;

    fetch_stage #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_stall        (id_stall),
`ifdef FETCH_STALL_CNT_EN
        .fetch_stall_cycles (stall_cycles),
`endif
        .if_valid        (if_valid),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) begin
        p1 <= imem_req_valid && imem_req_ready;
        a1 <= imem_req_addr;
        p2 <= p1;
        a2 <= a1;
    end

    assign imem_resp_valid = inj ? 1'b1 : (lat2 ? p2 : p1);
    assign imem_resp_data  = inj ? 32'hDEAD_BEEF : mdata(lat2 ? a2 : a1);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut(input logic slow);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        inj = 1'b0;
        lat2 = slow;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({imem_req_valid, imem_req_addr} !== 33'h0) begin
            $display("FAIL reset_req: got %b/%h expected 0/0",
                     imem_req_valid, imem_req_addr);
        end else n_pass++;
        n_total++;
        if ({if_valid, if_instruction, if_pc} !== 65'h0) begin
            $display("FAIL reset_if: got %b/%h/%h expected 0/0/0",
                     if_valid, if_instruction, if_pc);
        end else n_pass++;
    endtask

    task automatic test_sequential();
        logic        erv;
        logic [31:0] era;
        logic        eiv;
        logic [31:0] epc;
        reset_dut(1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            erv = (k % 2 == 1);
            era = 32'h100 + 32'(4 * ((k - 1) / 2));
            eiv = (k >= 3) && (k % 2 == 1);
            epc = 32'h100 + 32'(4 * ((k - 3) / 2));
            n_total++;
            if (imem_req_valid !== erv ||
                (erv && imem_req_addr !== era)) begin
                $display("FAIL seq_req k=%0d: got %b/%h expected %b/%h",
                         k, imem_req_valid, imem_req_addr, erv, era);
            end else n_pass++;
            n_total++;
            if (if_valid !== eiv || (eiv &&
                (if_pc !== epc || if_instruction !== mdata(epc)))) begin
                $display("FAIL seq_if k=%0d: got %b/%h/%h expected %b/%h/%h",
                         k, if_valid, if_pc, if_instruction,
                         eiv, epc, mdata(epc));
            end else n_pass++;
        end
    endtask

    task automatic test_stall_skid();
        reset_dut(1'b0);
        repeat (3) tick();
        id_stall = 1'b1;
        for (int k = 4; k <= 9; k++) begin
            tick();
            n_total++;
            if (imem_req_valid !== 1'b0) begin
                $display("FAIL stall_noreq k=%0d: got %b expected 0",
                         k, imem_req_valid);
            end else n_pass++;
            n_total++;
            if ({if_valid, if_pc, if_instruction} !==
                {1'b1, 32'h100, mdata(32'h100)}) begin
                $display("FAIL stall_hold k=%0d: got %b/%h/%h expected 1/%h/%h",
                         k, if_valid, if_pc, if_instruction,
                         32'h100, mdata(32'h100));
            end else n_pass++;
        end
        id_stall = 1'b0;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instruction} !==
            {1'b1, 32'h104, mdata(32'h104)}) begin
            $display("FAIL skid_out: got %b/%h/%h expected 1/%h/%h",
                     if_valid, if_pc, if_instruction, 32'h104, mdata(32'h104));
        end else n_pass++;
        n_total++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h108}) begin
            $display("FAIL skid_resume: got %b/%h expected 1/00000108",
                     imem_req_valid, imem_req_addr);
        end else n_pass++;
`ifdef FETCH_STALL_CNT_EN
        n_total++;
        if (stall_cycles !== 32'd7) begin
            $display("FAIL stall_cnt: got %0d expected 7", stall_cycles);
        end else n_pass++;
`endif
        tick();
        n_total++;
        if (if_valid !== 1'b0) begin
            $display("FAIL skid_consume: got %b expected 0", if_valid);
        end else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc} !== {1'b1, 32'h108}) begin
            $display("FAIL skid_next: got %b/%h expected 1/00000108",
                     if_valid, if_pc);
        end else n_pass++;
    endtask

    task automatic test_redirect_wait();
        reset_dut(1'b0);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        n_total++;
        if ({imem_req_valid, imem_req_addr, if_valid} !==
            {1'b1, 32'h2000, 1'b0}) begin
            $display("FAIL redir_wait_req: got %b/%h/%b expected 1/00002000/0",
                     imem_req_valid, imem_req_addr, if_valid);
        end else n_pass++;
        tick();
        n_total++;
        if (if_valid !== 1'b0) begin
            $display("FAIL redir_wait_drop: got %b/%h expected 0",
                     if_valid, if_pc);
        end else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instruction} !==
            {1'b1, 32'h2000, mdata(32'h2000)}) begin
            $display("FAIL redir_wait_if: got %b/%h/%h expected 1/00002000/%h",
                     if_valid, if_pc, if_instruction, mdata(32'h2000));
        end else n_pass++;
    endtask

    task automatic test_redirect_kill();
        reset_dut(1'b1);
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        n_total++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin
            $display("FAIL kill_wait: got %b/%b expected 0/0",
                     imem_req_valid, if_valid);
        end else n_pass++;
        tick();
        n_total++;
        if ({imem_req_valid, imem_req_addr, if_valid} !==
            {1'b1, 32'h3000, 1'b0}) begin
            $display("FAIL kill_req: got %b/%h/%b expected 1/00003000/0",
                     imem_req_valid, imem_req_addr, if_valid);
        end else n_pass++;
        repeat (2) tick();
        n_total++;
        if (if_valid !== 1'b0) begin
            $display("FAIL kill_drop: got %b/%h expected 0", if_valid, if_pc);
        end else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instruction} !==
            {1'b1, 32'h3000, mdata(32'h3000)}) begin
            $display("FAIL kill_if: got %b/%h/%h expected 1/00003000/%h",
                     if_valid, if_pc, if_instruction, mdata(32'h3000));
        end else n_pass++;
        lat2 = 1'b0;
    endtask

    task automatic test_redirect_fetch();
        reset_dut(1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_4000;
        tick();
        redirect_valid = 1'b0;
        n_total++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin
            $display("FAIL rf_wait: got %b/%b expected 0/0",
                     imem_req_valid, if_valid);
        end else n_pass++;
        tick();
        n_total++;
        if ({imem_req_valid, imem_req_addr, if_valid} !==
            {1'b1, 32'h4000, 1'b0}) begin
            $display("FAIL rf_req: got %b/%h/%b expected 1/00004000/0",
                     imem_req_valid, imem_req_addr, if_valid);
        end else n_pass++;
        repeat (2) tick();
        n_total++;
        if ({if_valid, if_pc} !== {1'b1, 32'h4000}) begin
            $display("FAIL rf_if: got %b/%h expected 1/00004000",
                     if_valid, if_pc);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        reset_dut(1'b0);
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        n_total++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            $display("FAIL wrap_req0: got %b/%h expected 1/fffffffc",
                     imem_req_valid, imem_req_addr);
        end else n_pass++;
        repeat (2) tick();
        n_total++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
            $display("FAIL wrap_req1: got %b/%h expected 1/00000000",
                     imem_req_valid, imem_req_addr);
        end else n_pass++;
        n_total++;
        if ({if_valid, if_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            $display("FAIL wrap_if: got %b/%h expected 1/fffffffc",
                     if_valid, if_pc);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        reset_dut(1'b0);
        repeat (3) tick();
        id_stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({imem_req_valid, imem_req_addr} !== 33'h0) begin
            $display("FAIL areset_req: got %b/%h expected 0/0",
                     imem_req_valid, imem_req_addr);
        end else n_pass++;
        n_total++;
        if ({if_valid, if_instruction, if_pc} !== 65'h0) begin
            $display("FAIL areset_if: got %b/%h/%h expected 0/0/0",
                     if_valid, if_instruction, if_pc);
        end else n_pass++;
        @(negedge clk);
        id_stall = 1'b0;
        rst_n = 1'b1;
        inj = 1'b1;
        tick();
        n_total++;
        if ({imem_req_valid, imem_req_addr, if_valid} !==
            {1'b1, 32'h100, 1'b0}) begin
            $display("FAIL areset_restart: got %b/%h/%b expected 1/00000100/0",
                     imem_req_valid, imem_req_addr, if_valid);
        end else n_pass++;
        tick();
        inj = 1'b0;
        n_total++;
        if (if_valid !== 1'b0) begin
            $display("FAIL areset_ignore: got %b/%h expected 0",
                     if_valid, if_instruction);
        end else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instruction} !==
            {1'b1, 32'h100, mdata(32'h100)}) begin
            $display("FAIL areset_if1: got %b/%h/%h expected 1/00000100/%h",
                     if_valid, if_pc, if_instruction, mdata(32'h100));
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_kill();
        test_redirect_fetch();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
